// File: rtl/cube_pkg.sv
// Shared definitions for the 3x3x3 LED cube driver.
// Frame bit index = plane*9 + row*3 + col, plane 0 = bottom.
package cube_pkg;

  localparam int unsigned PLANES         = 3;
  localparam int unsigned ROWS_PER_PLANE = 9;
  localparam int unsigned FRAME_W        = PLANES * ROWS_PER_PLANE;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BLANK = 2'b01,
    DRIVE = 2'b10
  } scan_state_e;

  // Row lines belonging to one plane of a frame; out-of-range plane gives 0.
  function automatic logic [ROWS_PER_PLANE-1:0] plane_slice(
    input logic [FRAME_W-1:0] frame,
    input logic [1:0]         plane
  );
    case (plane)
      2'd0:    return frame[0*ROWS_PER_PLANE +: ROWS_PER_PLANE];
      2'd1:    return frame[1*ROWS_PER_PLANE +: ROWS_PER_PLANE];
      2'd2:    return frame[2*ROWS_PER_PLANE +: ROWS_PER_PLANE];
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/cube_frame_buffer.sv
// Shadow/active frame registers for the cube scanner.
//   clock, reset_n : clock, asynchronous active-low reset
//   frame_data/frame_valid/frame_ready : input handshake into the shadow
//   swap_req       : scanner is leaving plane 2 (frame boundary)
//   active_frame   : frame currently being displayed
//   frame_swap     : one-cycle pulse after the shadow became active
module cube_frame_buffer
  import cube_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic               swap_req,
  output logic [FRAME_W-1:0] active_frame,
  output logic               frame_swap
);

  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [FRAME_W-1:0] active_q, active_d;
  logic               full_q, full_d;
  logic               ready_q, ready_d;
  logic               swap_q, swap_d;

  // Transfer and swap are mutually exclusive: ready is low whenever full.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    full_d   = full_q;
    swap_d   = 1'b0;
    if (frame_valid && ready_q) begin
      shadow_d = frame_data;
      full_d   = 1'b1;
    end
    if (swap_req && full_q) begin
      active_d = shadow_q;
      full_d   = 1'b0;
      swap_d   = 1'b1;
    end
    ready_d = ~full_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
      full_q   <= 1'b0;
      ready_q  <= 1'b1;
      swap_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      full_q   <= full_d;
      ready_q  <= ready_d;
      swap_q   <= swap_d;
    end
  end

  assign frame_ready  = ready_q;
  assign active_frame = active_q;
  assign frame_swap   = swap_q;

endmodule

// File: rtl/cube_plane_scanner.sv
// Plane-multiplexing driver for the 3x3x3 LED cube.
//   clock, reset_n : clock, asynchronous active-low reset
//   enable         : scan enable, low forces all lines off
//   frame_data/frame_valid/frame_ready : frame input handshake
//   vert_pwr       : one-hot plane power select
//   row            : row lines of the driven plane
//   plane_idx      : plane currently scanned
//   frame_swap     : pulse when a new frame becomes active
module cube_plane_scanner
  import cube_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [FRAME_W-1:0]        frame_data,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  output logic [PLANES-1:0]         vert_pwr,
  output logic [ROWS_PER_PLANE-1:0] row,
  output logic [1:0]                plane_idx,
  output logic                      frame_swap
);

  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [1:0]       LAST_PLANE = 2'(PLANES - 1);

  scan_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                plane_q, plane_d;
  logic [PLANES-1:0]         vert_q, vert_d;
  logic [ROWS_PER_PLANE-1:0] row_q, row_d;
  logic                      swap_req;
  logic [FRAME_W-1:0]        active_frame;

  cube_frame_buffer u_frame_buffer (
    .clock        (clock),
    .reset_n      (reset_n),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .swap_req     (swap_req),
    .active_frame (active_frame),
    .frame_swap   (frame_swap)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    plane_d  = plane_q;
    swap_req = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      plane_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == SCAN_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (plane_q == LAST_PLANE) begin
              plane_d  = '0;
              swap_req = 1'b1;
            end else begin
              plane_d = plane_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          plane_d = '0;
        end
      endcase
    end

    // Outputs are registered, so decode from the next state/plane.
    vert_d = '0;
    row_d  = '0;
    if (state_d == DRIVE) begin
      vert_d = PLANES'(1) << plane_d;
      row_d  = plane_slice(active_frame, plane_d);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      plane_q <= '0;
      vert_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      plane_q <= plane_d;
      vert_q  <= vert_d;
      row_q   <= row_d;
    end
  end

  assign vert_pwr  = vert_q;
  assign row       = row_q;
  assign plane_idx = plane_q;

endmodule

// File: tb/tb_cube_plane_scanner.sv
module tb_cube_plane_scanner;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [26:0] frame_data = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [2:0]  vert_pwr;
  logic [8:0]  row;
  logic [1:0]  plane_idx;
  logic        frame_swap;

  int checks = 0;
  int errors = 0;

  localparam logic [26:0] F1 = 27'h7FC01FF;
  localparam logic [26:0] F2 = {9'h0F0, 9'h15A, 9'h0A5};
  localparam logic [26:0] F3 = {9'h111, 9'h0C3, 9'h1E7};
  localparam logic [26:0] F4 = {9'h1AA, 9'h055, 9'h100};

  always #5 clock = ~clock;

  cube_plane_scanner #(
    .SCAN_DIV     (4),
    .BLANK_CYCLES (2),
    .CNT_W        (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .vert_pwr    (vert_pwr),
    .row         (row),
    .plane_idx   (plane_idx),
    .frame_swap  (frame_swap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_check(input string tag, input logic [2:0] vp, input logic [8:0] rw,
                            input logic [1:0] pi, input logic sw, input logic rdy);
    @(negedge clock);
    chk({tag, " vert_pwr"},    32'(vert_pwr),    32'(vp));
    chk({tag, " row"},         32'(row),         32'(rw));
    chk({tag, " plane_idx"},   32'(plane_idx),   32'(pi));
    chk({tag, " frame_swap"},  32'(frame_swap),  32'(sw));
    chk({tag, " frame_ready"}, 32'(frame_ready), 32'(rdy));
  endtask

  // One plane visit: 2 blank cycles then 4 drive cycles.
  task automatic expect_visit(input string tag, input logic [1:0] p, input logic [8:0] rw,
                              input logic sw_first, input logic rdy_first, input logic rdy_rest);
    logic [2:0] vp;
    vp = 3'b001 << p;
    tick_check({tag, " blank0"}, 3'b000, 9'h000, p, sw_first, rdy_first);
    tick_check({tag, " blank1"}, 3'b000, 9'h000, p, 1'b0, rdy_rest);
    for (int i = 0; i < 4; i++)
      tick_check({tag, " drive"}, vp, rw, p, 1'b0, rdy_rest);
  endtask

  // Plane select never multi-hot; rows dark while no plane powered.
  always @(negedge clock) begin
    if (reset_n) begin
      checks++;
      assert (($countones(vert_pwr) <= 1) && !((vert_pwr === 3'b000) && (row !== 9'h000))) else begin
        errors++;
        $error("FAIL invariant: observed vert_pwr=%0h row=%0h expected one-hot-or-zero and dark rows", vert_pwr, row);
      end
    end
  end

  initial begin
    #2 reset_n = 1'b0;
    tick_check("reset", 3'b000, 9'h000, 2'd0, 1'b0, 1'b1);
    reset_n = 1'b1;
    tick_check("idle", 3'b000, 9'h000, 2'd0, 1'b0, 1'b1);

    // Empty frame, full scan plus wrap.
    enable = 1'b1;
    expect_visit("t1 p0", 2'd0, 9'h000, 1'b0, 1'b1, 1'b1);
    expect_visit("t1 p1", 2'd1, 9'h000, 1'b0, 1'b1, 1'b1);
    expect_visit("t1 p2", 2'd2, 9'h000, 1'b0, 1'b1, 1'b1);
    expect_visit("t1 wrap", 2'd0, 9'h000, 1'b0, 1'b1, 1'b1);

    // Frame accepted mid-scan, swapped only at the plane-2 exit.
    frame_data  = F1;
    frame_valid = 1'b1;
    expect_visit("t2 p1", 2'd1, 9'h000, 1'b0, 1'b0, 1'b0);
    frame_valid = 1'b0;
    frame_data  = '1;
    expect_visit("t2 p2", 2'd2, 9'h000, 1'b0, 1'b0, 1'b0);
    expect_visit("t2 f1p0", 2'd0, 9'h1FF, 1'b1, 1'b1, 1'b1);
    expect_visit("t2 f1p1", 2'd1, 9'h000, 1'b0, 1'b1, 1'b1);
    expect_visit("t2 f1p2", 2'd2, 9'h1FF, 1'b0, 1'b1, 1'b1);

    // F2 into shadow, F3 held while shadow full.
    frame_data  = F2;
    frame_valid = 1'b1;
    expect_visit("t3 f1p0", 2'd0, 9'h1FF, 1'b0, 1'b0, 1'b0);
    frame_data = F3;
    expect_visit("t3 f1p1", 2'd1, 9'h000, 1'b0, 1'b0, 1'b0);
    expect_visit("t3 f1p2", 2'd2, 9'h1FF, 1'b0, 1'b0, 1'b0);
    expect_visit("t3 f2p0", 2'd0, 9'h0A5, 1'b1, 1'b1, 1'b0);
    frame_valid = 1'b0;
    frame_data  = '0;
    expect_visit("t3 f2p1", 2'd1, 9'h15A, 1'b0, 1'b0, 1'b0);
    expect_visit("t3 f2p2", 2'd2, 9'h0F0, 1'b0, 1'b0, 1'b0);
    expect_visit("t3 f3p0", 2'd0, 9'h1E7, 1'b1, 1'b1, 1'b1);

    // Enable dropped during plane 1 drive.
    tick_check("t4 blank", 3'b000, 9'h000, 2'd1, 1'b0, 1'b1);
    tick_check("t4 blank", 3'b000, 9'h000, 2'd1, 1'b0, 1'b1);
    tick_check("t4 drive", 3'b010, 9'h0C3, 2'd1, 1'b0, 1'b1);
    tick_check("t4 drive", 3'b010, 9'h0C3, 2'd1, 1'b0, 1'b1);
    enable = 1'b0;
    tick_check("t4 off", 3'b000, 9'h000, 2'd0, 1'b0, 1'b1);
    tick_check("t4 off", 3'b000, 9'h000, 2'd0, 1'b0, 1'b1);
    enable = 1'b1;
    expect_visit("t4 re p0", 2'd0, 9'h1E7, 1'b0, 1'b1, 1'b1);

    // Reset mid-drive with the shadow full.
    frame_data  = F4;
    frame_valid = 1'b1;
    tick_check("t5 blank", 3'b000, 9'h000, 2'd1, 1'b0, 1'b0);
    frame_valid = 1'b0;
    tick_check("t5 blank", 3'b000, 9'h000, 2'd1, 1'b0, 1'b0);
    tick_check("t5 drive", 3'b010, 9'h0C3, 2'd1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t5 async vert_pwr",    32'(vert_pwr),    32'd0);
    chk("t5 async row",         32'(row),         32'd0);
    chk("t5 async plane_idx",   32'(plane_idx),   32'd0);
    chk("t5 async frame_swap",  32'(frame_swap),  32'd0);
    chk("t5 async frame_ready", 32'(frame_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    expect_visit("t5 p0", 2'd0, 9'h000, 1'b0, 1'b1, 1'b1);
    expect_visit("t5 p1", 2'd1, 9'h000, 1'b0, 1'b1, 1'b1);
    expect_visit("t5 p2", 2'd2, 9'h000, 1'b0, 1'b1, 1'b1);
    expect_visit("t5 noswap", 2'd0, 9'h000, 1'b0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
